mmio_bus_bridge: RTL and testbench
==================================

// Module: mmio_bus_bridge
// PURPOSE
//  Bridges the processor IO bus (single outstanding strobe/ready transaction) to the
//  slot bus that feeds all MMIO cores: timer, GPIO, UART and so on.
//  - Decodes a byte address into a one-hot slot chip-select plus a 5-bit register address.
//  - Drives one-cycle read/write pulses to the selected slot.
//  - Captures the slot's combinational rd_data and returns it with io_ready.
//  - Flags out-of-window, unmapped, partial-write and protocol-violation accesses.
// PARAMETERS
//  BASE_ADDR  32'hC000_0000  IO window base; io_address[31:24] must equal BASE_ADDR[31:24]
//  NUM_SLOTS  64             number of slots (1..64); slot index = io_address[12:7]
//  ERR_DATA   32'hDEAD_BEEF  read data returned on any errored read
// PORTS
//  clk              in   1            system clock
//  reset            in   1            asynchronous, active-high reset
//  io_addr_strobe   in   1            transaction request, 1-cycle pulse
//  io_read_strobe   in   1            read qualifier, valid with io_addr_strobe
//  io_write_strobe  in   1            write qualifier, valid with io_addr_strobe
//  io_address       in   32           byte address
//  io_byte_enable   in   4            byte lanes; writes require 4'hF
//  io_write_data    in   32           write data
//  io_read_data     out  32           read data, valid while io_ready=1
//  io_ready         out  1            transaction complete, 1-cycle pulse
//  fp_cs            out  NUM_SLOTS    one-hot slot select
//  fp_read          out  1            slot read pulse
//  fp_write         out  1            slot write pulse
//  fp_reg_addr      out  5            register index inside slot = io_address[6:2]
//  fp_wr_data       out  32           registered write data
//  fp_rd_data       in   NUM_SLOTS*32 flattened slot read data; slot k at [32k+31:32k]
//  err_clr          in   1            clears err_flag and err_addr
//  err_flag         out  1            sticky error indicator
//  err_addr         out  32           io_address of the first error since the last clear
// BEHAVIOUR
//  - Reset: FSM=IDLE; every output and internal register is 0; no io_ready is issued
//    for a transaction in flight when reset asserts.
//  - FSM states:
//    - IDLE -> ACCESS on io_addr_strobe. Latch address, data, byte enables, rd/wr.
//      Decode validity in the same cycle.
//    - ACCESS: lasts exactly 1 cycle.
//      - Valid access: fp_cs[slot]=1, plus fp_read or fp_write =1, fp_reg_addr and
//        fp_wr_data driven from latches.
//      - Slot read data is sampled into the read register at the end of this cycle.
//      - Errored access: fp_cs, fp_read and fp_write all stay 0.
//      - Next state: RESP.
//    - RESP: io_ready=1 for 1 cycle; io_read_data = captured data, ERR_DATA if the read
//      errored, 0 for writes. Next state: IDLE.
//  - Latency: strobe in cycle T, slot pulse in T+1, io_ready in T+2. Fixed for every access.
//  - Back-to-back: a new strobe is accepted in the cycle after io_ready (state IDLE).
//  - Error conditions (each still completes with io_ready at T+2, no slot access):
//    - io_address[31:24] != BASE_ADDR[31:24]
//    - slot index >= NUM_SLOTS
//    - write with io_byte_enable != 4'hF
//    - read_strobe and write_strobe both 1, or both 0
//  - Strobe while in ACCESS/RESP: ignored (no new transaction, no change to the current
//    one). Sets err_flag; err_addr takes that address if err_flag was 0.
//  - err_flag: set on any error and held until err_clr.
//    - err_addr latches only on a 0->1 transition of err_flag.
//    - err_clr and a new error in the same cycle: the error wins (flag=1, addr=new).
//  - fp_wr_data and fp_reg_addr hold their last value outside ACCESS. fp_cs, fp_read and
//    fp_write are 0 outside ACCESS.
// STRUCTURE
//  - mmio_pkg:
//    - DATA_W=32, REG_ADDR_W=5, SLOT_ADDR_W=6
//    - typedef enum logic [1:0] {IDLE, ACCESS, RESP} bridge_state_t
//    - the slot/reg bit-field positions within io_address
//  - Sub-module mmio_slot_decoder: combinational slot index + enable -> one-hot fp_cs,
//    with a NUM_SLOTS range check that outputs slot_valid.
//  - FSM, latches, read-data mux and error logic live in the top level.
// TESTING
//  1. Timer at slot 2. Write 0xC000_0108 data 0x3 (BE=F) -> T+1: fp_cs[2]=1, fp_write=1,
//     fp_reg_addr=2, fp_wr_data=3; T+2: io_ready=1, io_read_data=0.
//  2. Slot 2 rd_data=0x0000_1234, read 0xC000_0100 -> fp_read=1 at T+1;
//     io_read_data=0x0000_1234 with io_ready at T+2.
//  3. Read 0xB000_0100 -> no fp_cs; io_read_data=0xDEAD_BEEF at T+2;
//     err_flag=1, err_addr=0xB000_0100.
//  4. Write BE=4'h3 to 0xC000_0108 -> fp_write never asserts; io_ready at T+2; err_flag=1.
//     Pulse err_clr -> err_flag=0, err_addr=0.
//  5. Strobe at T and again at T+1 -> exactly one ACCESS and one io_ready; err_flag=1,
//     err_addr = second address.
//  6. Assert reset during ACCESS -> all outputs 0 next cycle, no io_ready. After release,
//     a read of 0xC000_0104 completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared widths, io_address field positions and bridge FSM states
package mmio_pkg;
    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int SLOT_ADDR_W = 6;
    localparam int REG_LSB     = 2;
    localparam int SLOT_LSB    = 7;
    localparam int WIN_LSB     = 24;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} bridge_state_t;
endpackage

// File: rtl/mmio_slot_decoder.sv
// mmio_slot_decoder: slot index to one-hot chip select with NUM_SLOTS range check
module mmio_slot_decoder
    import mmio_pkg::*;
#(
    parameter int NUM_SLOTS = 64
) (
    input  logic [SLOT_ADDR_W-1:0] i_slot,
    input  logic                   i_en,
    output logic [NUM_SLOTS-1:0]   o_cs,
    output logic                   o_slot_valid
);
    assign o_slot_valid = 32'(i_slot) < NUM_SLOTS;
    always_comb begin
        o_cs = '0;
        for (int k = 0; k < NUM_SLOTS; k++) o_cs[k] = i_en && (32'(i_slot) == k);
    end
endmodule

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: IO bus strobe/ready to slot bus bridge with fixed two-cycle latency
// and sticky error capture
module mmio_bus_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          NUM_SLOTS = 64,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_addr_strobe,
    input  logic                        io_read_strobe,
    input  logic                        io_write_strobe,
    input  logic [31:0]                 io_address,
    input  logic [3:0]                  io_byte_enable,
    input  logic [DATA_W-1:0]           io_write_data,
    output logic [DATA_W-1:0]           io_read_data,
    output logic                        io_ready,
    output logic [NUM_SLOTS-1:0]        fp_cs,
    output logic                        fp_read,
    output logic                        fp_write,
    output logic [REG_ADDR_W-1:0]       fp_reg_addr,
    output logic [DATA_W-1:0]           fp_wr_data,
    input  logic [NUM_SLOTS*DATA_W-1:0] fp_rd_data,
    input  logic                        err_clr,
    output logic                        err_flag,
    output logic [31:0]                 err_addr
);
    bridge_state_t          r_state, w_next;
    logic [SLOT_ADDR_W-1:0] r_slot, w_dec_slot;
    logic [REG_ADDR_W-1:0]  r_reg;
    logic [DATA_W-1:0]      r_wdata, r_rdata, w_rd_sel;
    logic [31:0]            r_err_addr;
    logic                   r_rd, r_wr, r_bad, r_err_flag;
    logic                   w_accept, w_bad, w_err_evt, w_slot_valid, w_live;
    logic                   w_unused;

    assign w_unused = ^{io_address[WIN_LSB-1:SLOT_LSB+SLOT_ADDR_W], io_address[REG_LSB-1:0]};
    // The decoder range-checks the incoming address in IDLE and selects the latched slot in ACCESS
    assign w_dec_slot = (r_state == IDLE) ? io_address[SLOT_LSB +: SLOT_ADDR_W] : r_slot;
    assign w_live     = (r_state == ACCESS) && !r_bad;

    mmio_slot_decoder #(.NUM_SLOTS(NUM_SLOTS)) u_dec (
        .i_slot       (w_dec_slot),
        .i_en         (w_live),
        .o_cs         (fp_cs),
        .o_slot_valid (w_slot_valid)
    );

    assign w_accept  = (r_state == IDLE) && io_addr_strobe;
    assign w_bad     = (io_address[31:WIN_LSB] != BASE_ADDR[31:WIN_LSB]) || !w_slot_valid ||
                       (io_read_strobe == io_write_strobe) || (io_write_strobe && io_byte_enable != 4'hF);
    assign w_err_evt = io_addr_strobe && ((r_state != IDLE) || w_bad);

    always_comb w_next = (r_state == IDLE) ? (io_addr_strobe ? ACCESS : IDLE) :
                         (r_state == ACCESS) ? RESP : IDLE;

    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            if (r_slot == SLOT_ADDR_W'(k)) w_rd_sel = fp_rd_data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_slot     <= '0;
            r_reg      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_bad      <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_slot  <= io_address[SLOT_LSB +: SLOT_ADDR_W];
                r_reg   <= io_address[REG_LSB +: REG_ADDR_W];
                r_wdata <= io_write_data;
                r_rd    <= io_read_strobe;
                r_wr    <= io_write_strobe;
                r_bad   <= w_bad;
            end
            if (r_state == ACCESS)
                r_rdata <= !r_rd ? '0 : r_bad ? ERR_DATA : w_rd_sel;
            // A new error outranks a simultaneous clear
            r_err_flag <= w_err_evt || (r_err_flag && !err_clr);
            if (w_err_evt && (!r_err_flag || err_clr)) r_err_addr <= io_address;
            else if (err_clr) r_err_addr <= '0;
        end
    end

    assign fp_read      = w_live && r_rd;
    assign fp_write     = w_live && r_wr;
    assign fp_reg_addr  = r_reg;
    assign fp_wr_data   = r_wdata;
    assign io_ready     = (r_state == RESP);
    assign io_read_data = io_ready ? r_rdata : '0;
    assign err_flag     = r_err_flag;
    assign err_addr     = r_err_addr;
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb_mmio_bus_bridge: directed stimulus against a cycle-schedule model of the bridge
// plus literal expectations from the worked examples
module tb_mmio_bus_bridge;
    logic           clk = 0, reset = 1;
    logic           io_addr_strobe = 0, io_read_strobe = 0, io_write_strobe = 0;
    logic [31:0]    io_address = 0, io_write_data = 0;
    logic [3:0]     io_byte_enable = 0;
    logic [31:0]    io_read_data;
    logic           io_ready, fp_read, fp_write, err_clr = 0, err_flag;
    logic [63:0]    fp_cs;
    logic [4:0]     fp_reg_addr;
    logic [31:0]    fp_wr_data, err_addr;
    logic [2047:0]  fp_rd_data;
    logic [31:0]    slot_mem [64];
    int             n_cmp = 0, n_bad = 0;

    mmio_bus_bridge dut (
        .clk(clk), .reset(reset), .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address), .io_byte_enable(io_byte_enable),
        .io_write_data(io_write_data), .io_read_data(io_read_data), .io_ready(io_ready),
        .fp_cs(fp_cs), .fp_read(fp_read), .fp_write(fp_write), .fp_reg_addr(fp_reg_addr),
        .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data), .err_clr(err_clr),
        .err_flag(err_flag), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    always_comb begin
        fp_rd_data = '0;
        for (int k = 0; k < 64; k++) fp_rd_data[k*32 +: 32] = slot_mem[k];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected outputs per future cycle, filled when a strobe is accepted
    typedef struct packed {
        logic [63:0] cs;
        logic        rd, wr, rdy;
        logic [31:0] rdata;
    } exp_t;
    exp_t        sched [4];
    exp_t        e;
    int          cyc = 0, free_at = 0;
    logic        m_flag = 0, m_err, m_ev;
    logic [31:0] m_eaddr = 0, m_wd = 0;
    logic [4:0]  m_reg = 0;
    int          m_slot;

    initial for (int i = 0; i < 4; i++) sched[i] = '0;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) sched[i] = '0;
            free_at = 0; m_flag = 0; m_eaddr = 0; m_wd = 0; m_reg = 0;
        end
        e = sched[cyc % 4];
        chk("fp_cs", fp_cs, e.cs);
        chk("fp_read", fp_read, e.rd);
        chk("fp_write", fp_write, e.wr);
        chk("io_ready", io_ready, e.rdy);
        chk("io_read_data", io_read_data, e.rdy ? e.rdata : 32'h0);
        chk("fp_reg_addr", fp_reg_addr, m_reg);
        chk("fp_wr_data", fp_wr_data, m_wd);
        chk("err_flag", err_flag, m_flag);
        chk("err_addr", err_addr, m_eaddr);
        sched[cyc % 4] = '0;
        if (!reset) begin
            m_ev = 0;
            if (io_addr_strobe) begin
                if (cyc < free_at) m_ev = 1;
                else begin
                    m_slot = int'(io_address[12:7]);
                    m_err  = io_address[31:24] != 8'hC0 || m_slot >= 64 ||
                             io_read_strobe == io_write_strobe ||
                             (io_write_strobe && io_byte_enable != 4'hF);
                    m_ev   = m_err;
                    if (!m_err) begin
                        sched[(cyc + 1) % 4].cs = 64'd1 << m_slot;
                        sched[(cyc + 1) % 4].rd = io_read_strobe;
                        sched[(cyc + 1) % 4].wr = io_write_strobe;
                    end
                    sched[(cyc + 2) % 4].rdy   = 1;
                    sched[(cyc + 2) % 4].rdata = !io_read_strobe ? 32'h0 :
                                                 m_err ? 32'hDEAD_BEEF : slot_mem[m_slot];
                    m_reg   = io_address[6:2];
                    m_wd    = io_write_data;
                    free_at = cyc + 3;
                end
            end
            if (m_ev) begin
                if (!m_flag || err_clr) m_eaddr = io_address;
                m_flag = 1;
            end else if (err_clr) begin
                m_flag = 0; m_eaddr = 0;
            end
        end
        cyc++;
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        io_addr_strobe = 1; io_read_strobe = rd; io_write_strobe = wr;
        io_address = a; io_byte_enable = be; io_write_data = d;
        @(posedge clk); #1;
        io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
    endtask

    task automatic clear_err();
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        @(negedge clk);
        chk("lit clr flag", err_flag, 0);
        chk("lit clr addr", err_addr, 0);
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic rd, wr;
        logic [31:0] a;
        logic [3:0] be;
        logic [31:0] d;
    } vec_t;
    vec_t vecs [7];
    int   rdy_cnt;

    initial begin
        for (int k = 0; k < 64; k++) slot_mem[k] = 32'h0;
        slot_mem[2]  = 32'h0000_1234;
        slot_mem[5]  = 32'h0BAD_F00D;
        slot_mem[63] = 32'hA5A5_0063;
        vecs[0] = '{1'b0, 1'b1, 32'hC000_1FFC, 4'hF, 32'h1111_2222};
        vecs[1] = '{1'b1, 1'b0, 32'hC000_1F80, 4'hF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'hC000_028C, 4'h0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'hC000_0100, 4'hF, 32'h5};
        vecs[4] = '{1'b1, 1'b1, 32'hC000_0200, 4'hF, 32'h6};
        vecs[5] = '{1'b1, 1'b0, 32'hC100_0100, 4'hF, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'hC000_0504, 4'hF, 32'hCAFE_0A0A};

        repeat (2) @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("lit reset ready", io_ready, 0);
        chk("lit reset cs", fp_cs, 0);
        chk("lit reset flag", err_flag, 0);
        @(posedge clk); #1;

        issue(0, 1, 32'hC000_0108, 4'hF, 32'h3);
        @(negedge clk);
        chk("lit t1 cs", fp_cs, 64'h4);
        chk("lit t1 write", fp_write, 1);
        chk("lit t1 reg", fp_reg_addr, 2);
        chk("lit t1 wdata", fp_wr_data, 3);
        @(negedge clk);
        chk("lit t1 ready", io_ready, 1);
        chk("lit t1 rdata", io_read_data, 0);
        @(posedge clk); #1;

        issue(1, 0, 32'hC000_0100, 4'hF, 32'h0);
        @(negedge clk);
        chk("lit t2 read", fp_read, 1);
        @(negedge clk);
        chk("lit t2 ready", io_ready, 1);
        chk("lit t2 rdata", io_read_data, 32'h0000_1234);
        @(posedge clk); #1;

        issue(1, 0, 32'hB000_0100, 4'hF, 32'h0);
        @(negedge clk);
        chk("lit t3 cs", fp_cs, 0);
        @(negedge clk);
        chk("lit t3 rdata", io_read_data, 32'hDEAD_BEEF);
        chk("lit t3 flag", err_flag, 1);
        chk("lit t3 eaddr", err_addr, 32'hB000_0100);
        @(posedge clk); #1;
        clear_err();

        issue(0, 1, 32'hC000_0108, 4'h3, 32'h7);
        @(negedge clk);
        chk("lit t4 write", fp_write, 0);
        @(negedge clk);
        chk("lit t4 ready", io_ready, 1);
        chk("lit t4 flag", err_flag, 1);
        @(posedge clk); #1;
        clear_err();

        io_addr_strobe = 1; io_read_strobe = 1; io_byte_enable = 4'hF;
        io_address = 32'hC000_0100;
        @(posedge clk); #1;
        io_address = 32'hC000_0180;
        @(posedge clk); #1;
        io_addr_strobe = 0; io_read_strobe = 0;
        rdy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (io_ready) rdy_cnt++;
        end
        chk("lit t5 ready count", 64'(rdy_cnt), 1);
        chk("lit t5 flag", err_flag, 1);
        chk("lit t5 eaddr", err_addr, 32'hC000_0180);
        @(posedge clk); #1;
        clear_err();

        foreach (vecs[i]) begin
            issue(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].d);
            repeat (2) @(posedge clk); #1;
        end
        clear_err();

        issue(1, 0, 32'hC000_0100, 4'hF, 32'h0);
        reset = 1;
        @(negedge clk);
        chk("lit t6 ready", io_ready, 0);
        chk("lit t6 cs", fp_cs, 0);
        chk("lit t6 read", fp_read, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("lit t6 no ready", io_ready, 0);
        @(posedge clk); #1;
        issue(1, 0, 32'hC000_0104, 4'hF, 32'h0);
        @(negedge clk);
        chk("lit t6b read", fp_read, 1);
        chk("lit t6b reg", fp_reg_addr, 1);
        @(negedge clk);
        chk("lit t6b ready", io_ready, 1);
        chk("lit t6b rdata", io_read_data, 32'h0000_1234);
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
